q_out_pack8: RTL and testbench

- Sits directly downstream of the 8-bit quantized add/multiply stages.
- Collects the unstallable 8-bit result stream (enable + data) and packs four results into one 32-bit word, little-endian.
- Writes packed words to the activation SRAM at consecutive word addresses from a programmed base.
- A small FIFO absorbs memory-port stalls, and a sticky flag reports any loss.

---
 rtl/npu_pkg.sv | 38 +++
 rtl/q_out_pack8_if.sv | 28 ++
 rtl/npu_sync_fifo.sv | 61 ++++++
 rtl/q_out_pack8.sv | 146 ++++++++++++++
 tb/tb_q_out_pack8.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared types and constants for the quantized-output packing path.
//   state_t      : packer job FSM states
//   pack_word_t  : {byte enables, packed 32-bit word} carried through the FIFO
//   lane_be()    : byte-enable mask for a word whose last filled lane is 'lane'
// -----------------------------------------------------------------------------
package npu_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   typedef struct packed {
      logic [LANES-1:0]  be;
      logic [WORD_W-1:0] data;
   } pack_word_t;

   // Lanes 0..lane are valid; lanes above hold zero.
   function automatic logic [LANES-1:0] lane_be(input logic [LANE_W-1:0] lane);
      lane_be = 4'b1111;
      case (lane)
         2'd0:    lane_be = 4'b0001;
         2'd1:    lane_be = 4'b0011;
         2'd2:    lane_be = 4'b0111;
         default: lane_be = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/q_out_pack8_if.sv
// -----------------------------------------------------------------------------
// q_out_pack8_if
// Activation-SRAM word write port.
//   MEM_WE/MEM_ADDR/MEM_WDATA/MEM_BE : write request from the packer
//   MEM_READY                        : SRAM accepts the write this cycle
// master = packer side, slave = memory side.
// -----------------------------------------------------------------------------
interface q_out_pack8_if #(
   parameter int unsigned ADDR_W = 16
) ();

   logic              MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [31:0]       MEM_WDATA;
   logic [3:0]        MEM_BE;
   logic              MEM_READY;

   modport master (
      output MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
      input  MEM_READY
   );

   modport slave (
      input  MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
      output MEM_READY
   );

endinterface

// File: rtl/npu_sync_fifo.sv
// -----------------------------------------------------------------------------
// npu_sync_fifo
// Single-clock FIFO; a push while full is accepted only if a pop happens in
// the same cycle (occupancy unchanged).
//   clk, rst_n    : clock, async active-low reset
//   i_push/i_data : write request and data
//   i_pop         : read request (ignored when empty)
//   o_data_c      : head entry (combinational from storage)
//   o_full_c      : no free entry
//   o_empty_c     : no valid entry
// -----------------------------------------------------------------------------
module npu_sync_fifo #(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data_c,
   output logic             o_full_c,
   output logic             o_empty_c
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W:0]   r_cnt;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty_c = (r_cnt == '0);
   assign o_full_c  = (r_cnt == FULL_CNT);
   assign o_data_c  = r_mem[r_rd];
   assign w_do_pop  = i_pop && !o_empty_c;
   assign w_do_push = i_push && (!o_full_c || w_do_pop);

   // Storage needs no reset; the consumer gates the head with o_empty_c.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PTR_W'(1);
         if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
         if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + (PTR_W+1)'(1);
         else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/q_out_pack8.sv
// -----------------------------------------------------------------------------
// q_out_pack8
// Packs an unstallable 8-bit result stream into little-endian 32-bit words and
// writes them to the activation SRAM at consecutive addresses from a base.
//   CLK, RESET_X           : clock, async active-low reset
//   START/BASE_ADDR/NUM_ELEM: job start pulse, first word address, byte count
//   INPUT_EN/D_IN          : result byte stream (no backpressure)
//   mem                    : SRAM write port (q_out_pack8_if.master)
//   BUSY/DONE/OVERFLOW     : job active, completion pulse, sticky word loss
// -----------------------------------------------------------------------------
module q_out_pack8
   import npu_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               CLK,
   input  logic               RESET_X,
   input  logic               START,
   input  logic [ADDR_W-1:0]  BASE_ADDR,
   input  logic [CNT_W-1:0]   NUM_ELEM,
   input  logic               INPUT_EN,
   input  logic [BYTE_W-1:0]  D_IN,
   q_out_pack8_if.master      mem,
   output logic               BUSY,
   output logic               DONE,
   output logic               OVERFLOW
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_num;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [LANE_W-1:0] r_lane;
   logic [WORD_W-1:0] r_pack;
   logic              r_busy;
   logic              r_done;
   logic              r_ovf;
   logic              w_start;
   logic              w_accept;
   logic              w_last;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   pack_word_t        w_push_word;
   pack_word_t        w_head;

   assign w_start  = START && (r_state == ST_IDLE);
   assign w_accept = INPUT_EN && (r_state == ST_RUN) && (r_cnt != r_num);
   assign w_last   = ((r_cnt + CNT_W'(1)) == r_num);
   // Word leaves the pack register in the same cycle its last byte arrives,
   // so it is at the FIFO head (MEM_WE) one cycle later.
   assign w_push   = w_accept && ((r_lane == LANE_W'(LANES-1)) || w_last);
   assign w_pop    = !w_empty && mem.MEM_READY;

   assign w_push_word.be   = lane_be(r_lane);
   assign w_push_word.data = r_pack | (WORD_W'(D_IN) << {r_lane, 3'b000});

   npu_sync_fifo #(
      .WIDTH ($bits(pack_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET_X),
      .i_push    (w_push),
      .i_data    (w_push_word),
      .i_pop     (w_pop),
      .o_data_c  (w_head),
      .o_full_c  (w_full),
      .o_empty_c (w_empty)
   );

   // Memory port: head of FIFO plus running address; zero when idle.
   assign mem.MEM_WE    = !w_empty;
   assign mem.MEM_ADDR  = r_addr;
   assign mem.MEM_WDATA = w_empty ? '0 : w_head.data;
   assign mem.MEM_BE    = w_empty ? '0 : w_head.be;

   assign BUSY     = r_busy;
   assign DONE     = r_done;
   assign OVERFLOW = r_ovf;

   // Job FSM: next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (START) w_state_nxt = (NUM_ELEM == '0) ? ST_FIN : ST_RUN;
         ST_RUN:   if (r_cnt == r_num) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_empty) w_state_nxt = ST_FIN;
         ST_FIN:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Job FSM: state register with registered BUSY/DONE decoded from next state.
   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
         r_done  <= (w_state_nxt == ST_FIN);
      end
   end

   // Element/lane counters, pack register, address counter, overflow flag.
   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         r_num  <= '0;
         r_cnt  <= '0;
         r_lane <= '0;
         r_pack <= '0;
         r_addr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_start) begin
            r_num  <= NUM_ELEM;
            r_cnt  <= '0;
            r_lane <= '0;
            r_pack <= '0;
         end else if (w_accept) begin
            // Counter advances even if the word is dropped, so the job ends.
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_push) begin
               r_lane <= '0;
               r_pack <= '0;
            end else begin
               r_lane <= r_lane + LANE_W'(1);
               r_pack <= w_push_word.data;
            end
         end

         if (w_start)     r_addr <= BASE_ADDR;
         else if (w_pop)  r_addr <= r_addr + ADDR_W'(1);

         if (w_start)                           r_ovf <= 1'b0;
         else if (w_push && w_full && !w_pop)   r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_q_out_pack8.sv
// -----------------------------------------------------------------------------
// tb_q_out_pack8
// Self-checking bench: per-scenario tasks drive jobs and compare captured SRAM
// writes against words built directly from the byte list of each job.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_q_out_pack8;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic        clk = 1'b0;
   logic        RESET_X;
   logic        START;
   logic [15:0] BASE_ADDR;
   logic [15:0] NUM_ELEM;
   logic        INPUT_EN;
   logic [7:0]  D_IN;
   logic        BUSY;
   logic        DONE;
   logic        OVERFLOW;

   q_out_pack8_if #(.ADDR_W(16)) mem_if ();

   q_out_pack8 #(.ADDR_W(16), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .CLK       (clk),
      .RESET_X   (RESET_X),
      .START     (START),
      .BASE_ADDR (BASE_ADDR),
      .NUM_ELEM  (NUM_ELEM),
      .INPUT_EN  (INPUT_EN),
      .D_IN      (D_IN),
      .mem       (mem_if),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   wr_t  cap_q[$];
   wr_t  exp_q[$];
   logic [7:0] job_bytes[$];
   int   done_cnt = 0, busy_cnt = 0, we_cnt = 0;
   int   stab_viol = 0, stab_samples = 0;
   int   rdy_mode = 0;
   int   cap_start, done_start;
   bit   job_to;

   // MEM_READY pattern: 0 always 1, 1 toggle, 2 low for 40 cycles, 3 random
   // with a guaranteed ready every fourth cycle.
   int stall_cnt = 0;
   int rdy_phase = 0;
   always @(posedge clk) begin
      #1;
      rdy_phase++;
      if (rdy_mode != 2) stall_cnt = 0;
      case (rdy_mode)
         1:       mem_if.MEM_READY = ~mem_if.MEM_READY;
         2: begin
            mem_if.MEM_READY = (stall_cnt >= 40);
            stall_cnt++;
         end
         3:       mem_if.MEM_READY = ((rdy_phase % 4) == 0) || ($urandom_range(1) == 1);
         default: mem_if.MEM_READY = 1'b1;
      endcase
   end

   // Observer: captures accepted writes, counts pulses, watches stall stability.
   logic prev_stall = 1'b0;
   wr_t  prev_w;
   always @(negedge clk) begin
      wr_t cur;
      cur = '{addr: mem_if.MEM_ADDR, data: mem_if.MEM_WDATA, be: mem_if.MEM_BE};
      if (RESET_X !== 1'b1) begin
         prev_stall = 1'b0;
      end else begin
         if (mem_if.MEM_WE === 1'b1 && mem_if.MEM_READY === 1'b1) cap_q.push_back(cur);
         if (DONE === 1'b1) done_cnt++;
         if (BUSY === 1'b1) busy_cnt++;
         if (mem_if.MEM_WE === 1'b1) we_cnt++;
         if (prev_stall) begin
            stab_samples++;
            if (mem_if.MEM_WE !== 1'b1 || cur !== prev_w) stab_viol++;
         end
         prev_stall = (mem_if.MEM_WE === 1'b1) && (mem_if.MEM_READY === 1'b0);
         prev_w     = cur;
      end
   end

   // Reference: word i holds bytes 4i..4i+3 little-endian, BE marks present
   // bytes, address base+i mod 2^16; only the first 'keep' words survive.
   function automatic void build_expected(input logic [15:0] base, input int n, input int keep);
      wr_t w;
      int  words;
      exp_q.delete();
      words = (n + 3) / 4;
      for (int i = 0; i < words && i < keep; i++) begin
         w.addr = base + 16'(i);
         w.data = '0;
         w.be   = '0;
         for (int k = 0; k < 4; k++) begin
            if (4*i + k < n) begin
               w.data[8*k +: 8] = job_bytes[4*i + k];
               w.be[k]          = 1'b1;
            end
         end
         exp_q.push_back(w);
      end
   endfunction

   function automatic void fill_random(input int n);
      job_bytes.delete();
      for (int i = 0; i < n; i++) job_bytes.push_back(8'($urandom));
   endfunction

   // Runs one job: START (with a stray byte in the IDLE cycle), n bytes from
   // job_bytes at en_pct density, optional ignored START mid-job, trailing
   // stray bytes, then waits for DONE within tmo cycles.
   task automatic run_job(input logic [15:0] base, input int n, input int en_pct,
                          input bit poke_start, input int tmo);
      int sent;
      int cyc;
      cap_start  = cap_q.size();
      done_start = done_cnt;
      job_to     = 1'b0;
      @(posedge clk); #1;
      START = 1'b1; BASE_ADDR = base; NUM_ELEM = 16'(n);
      INPUT_EN = 1'b1; D_IN = 8'hEE;
      @(posedge clk); #1;
      START = 1'b0; INPUT_EN = 1'b0;
      sent = 0;
      while (sent < n) begin
         if (int'($urandom_range(99)) < en_pct) begin
            INPUT_EN = 1'b1; D_IN = job_bytes[sent]; sent++;
         end else begin
            INPUT_EN = 1'b0; D_IN = 8'($urandom);
         end
         if (poke_start && sent == 1) begin
            START = 1'b1; BASE_ADDR = ~base; NUM_ELEM = 16'd3;
         end else begin
            START = 1'b0;
         end
         @(posedge clk); #1;
      end
      START = 1'b0;
      INPUT_EN = 1'b1; D_IN = 8'hEE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      INPUT_EN = 1'b0;
      cyc = 0;
      while (done_cnt == done_start && cyc < tmo) begin
         @(negedge clk);
         cyc++;
      end
      if (done_cnt == done_start) job_to = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      RESET_X = 1'b0; START = 1'b0; INPUT_EN = 1'b0;
      BASE_ADDR = '0; NUM_ELEM = '0; D_IN = '0; rdy_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_if.MEM_WE, mem_if.MEM_ADDR, mem_if.MEM_WDATA, mem_if.MEM_BE} !== 53'd0) begin
         errors++;
         $display("FAIL reset_mem got we=%b addr=%h data=%h be=%h want all 0",
                  mem_if.MEM_WE, mem_if.MEM_ADDR, mem_if.MEM_WDATA, mem_if.MEM_BE);
      end
      checks++;
      if ({BUSY, DONE, OVERFLOW} !== 3'b000) begin
         errors++;
         $display("FAIL reset_status got busy/done/ovf=%b%b%b want 000", BUSY, DONE, OVERFLOW);
      end
      @(posedge clk); #1;
      RESET_X = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_pack();
      int busy0;
      wr_t got;
      wr_t want_w1;
      // Full words
      job_bytes.delete();
      for (int i = 1; i <= 8; i++) job_bytes.push_back(8'(i));
      busy0 = busy_cnt;
      run_job(16'h0100, 8, 100, 1'b0, 200);
      build_expected(16'h0100, 8, 1000);
      checks++;
      if (job_to) begin errors++; $display("FAIL pack_full_timeout got no DONE want DONE"); end
      checks++;
      if (cap_q.size() - cap_start !== exp_q.size()) begin
         errors++;
         $display("FAIL pack_full_count got %0d want %0d", cap_q.size() - cap_start, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (cap_start + i < cap_q.size()) ? cap_q[cap_start + i] : '1;
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL pack_full_w%0d got %h want %h", i, got, exp_q[i]);
         end
      end
      checks++;
      if (done_cnt - done_start !== 1) begin
         errors++;
         $display("FAIL pack_full_done got %0d pulses want 1", done_cnt - done_start);
      end
      checks++;
      if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL pack_full_ovf got %b want 0", OVERFLOW); end
      checks++;
      if (busy_cnt <= busy0) begin errors++; $display("FAIL pack_full_busy got 0 busy cycles want >0"); end

      // Partial trailing word
      job_bytes.delete();
      for (int i = 0; i < 6; i++) job_bytes.push_back(8'(8'hA0 + i));
      run_job(16'h0200, 6, 100, 1'b0, 200);
      build_expected(16'h0200, 6, 1000);
      checks++;
      if (cap_q.size() - cap_start !== exp_q.size()) begin
         errors++;
         $display("FAIL pack_part_count got %0d want %0d", cap_q.size() - cap_start, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (cap_start + i < cap_q.size()) ? cap_q[cap_start + i] : '1;
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL pack_part_w%0d got %h want %h", i, got, exp_q[i]);
         end
      end
      want_w1 = '{addr: 16'h0201, data: 32'h0000A5A4, be: 4'b0011};
      got = (cap_start + 1 < cap_q.size()) ? cap_q[cap_start + 1] : '1;
      checks++;
      if (got !== want_w1) begin
         errors++;
         $display("FAIL pack_part_tail got %h want %h", got, want_w1);
      end
   endtask

   task automatic test_zero();
      int we0, busy0;
      we0 = we_cnt; busy0 = busy_cnt;
      @(posedge clk); #1;
      START = 1'b1; NUM_ELEM = 16'd0; BASE_ADDR = 16'h1234;
      @(posedge clk); #1;
      START = 1'b0;
      @(negedge clk);
      checks++;
      if (DONE !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", DONE); end
      @(negedge clk);
      checks++;
      if (DONE !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", DONE); end
      repeat (3) @(negedge clk);
      checks++;
      if (we_cnt !== we0) begin errors++; $display("FAIL zero_we got %0d write cycles want 0", we_cnt - we0); end
      checks++;
      if (busy_cnt !== busy0) begin errors++; $display("FAIL zero_busy got %0d busy cycles want 0", busy_cnt - busy0); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      int sv0, ss0;
      wr_t got;
      sv0 = stab_viol; ss0 = stab_samples;
      fill_random(32);
      rdy_mode = 2;
      run_job(16'h0300, 32, 100, 1'b0, 400);
      rdy_mode = 0;
      build_expected(16'h0300, 32, 4);
      checks++;
      if (job_to) begin errors++; $display("FAIL ovf_timeout got no DONE want DONE"); end
      checks++;
      if (cap_q.size() - cap_start !== exp_q.size()) begin
         errors++;
         $display("FAIL ovf_count got %0d want %0d", cap_q.size() - cap_start, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (cap_start + i < cap_q.size()) ? cap_q[cap_start + i] : '1;
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL ovf_w%0d got %h want %h", i, got, exp_q[i]);
         end
      end
      checks++;
      if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", OVERFLOW); end
      checks++;
      if (done_cnt - done_start !== 1) begin
         errors++;
         $display("FAIL ovf_done got %0d pulses want 1", done_cnt - done_start);
      end
      checks++;
      if (stab_samples <= ss0 || stab_viol !== sv0) begin
         errors++;
         $display("FAIL ovf_stable got %0d unstable of %0d stalls want 0 of >0",
                  stab_viol - sv0, stab_samples - ss0);
      end
      // Next START clears the sticky flag.
      @(posedge clk); #1;
      START = 1'b1; NUM_ELEM = 16'd0;
      @(posedge clk); #1;
      START = 1'b0;
      @(negedge clk);
      checks++;
      if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", OVERFLOW); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_toggle();
      int sv0, ss0;
      wr_t got;
      sv0 = stab_viol; ss0 = stab_samples;
      fill_random(64);
      rdy_mode = 1;
      run_job(16'h0400, 64, 100, 1'b0, 400);
      rdy_mode = 0;
      build_expected(16'h0400, 64, 1000);
      checks++;
      if (cap_q.size() - cap_start !== 16) begin
         errors++;
         $display("FAIL toggle_count got %0d want 16", cap_q.size() - cap_start);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (cap_start + i < cap_q.size()) ? cap_q[cap_start + i] : '1;
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL toggle_w%0d got %h want %h", i, got, exp_q[i]);
         end
      end
      checks++;
      if (OVERFLOW !== 1'b0 || job_to) begin
         errors++;
         $display("FAIL toggle_status got ovf=%b timeout=%b want 0 0", OVERFLOW, job_to);
      end
      checks++;
      if (stab_samples <= ss0 || stab_viol !== sv0) begin
         errors++;
         $display("FAIL toggle_stable got %0d unstable of %0d stalls want 0 of >0",
                  stab_viol - sv0, stab_samples - ss0);
      end
   endtask

   task automatic test_random();
      int n;
      logic [15:0] base;
      wr_t got;
      rdy_mode = 3;
      for (int j = 0; j < 6; j++) begin
         n    = int'($urandom_range(40, 1));
         base = (j == 0) ? 16'hFFFE : 16'($urandom);
         fill_random(n);
         run_job(base, n, 70, (j == 1), 500);
         build_expected(base, n, 1000);
         checks++;
         if (cap_q.size() - cap_start !== exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count got %0d want %0d", j, cap_q.size() - cap_start, exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            got = (cap_start + i < cap_q.size()) ? cap_q[cap_start + i] : '1;
            checks++;
            if (got !== exp_q[i]) begin
               errors++;
               $display("FAIL rand%0d_w%0d got %h want %h", j, i, got, exp_q[i]);
            end
         end
         checks++;
         if (done_cnt - done_start !== 1 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_status got done=%0d ovf=%b want 1 0", j, done_cnt - done_start, OVERFLOW);
         end
      end
      rdy_mode = 0;
   endtask

   task automatic test_wrap_reset();
      int  cap0, seen;
      wr_t got;
      wr_t want;
      cap0 = cap_q.size();
      @(posedge clk); #1;
      START = 1'b1; BASE_ADDR = 16'hFFFF; NUM_ELEM = 16'd8;
      @(posedge clk); #1;
      START = 1'b0; INPUT_EN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         D_IN = 8'(i + 1);
         @(posedge clk); #1;
      end
      INPUT_EN = 1'b0;
      @(negedge clk);
      want = '{addr: 16'hFFFF, data: 32'h04030201, be: 4'hF};
      got  = (cap0 < cap_q.size()) ? cap_q[cap0] : '1;
      checks++;
      if (got !== want) begin errors++; $display("FAIL wrap_first got %h want %h", got, want); end
      checks++;
      if (mem_if.MEM_ADDR !== 16'h0000 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL wrap_next_addr got addr=%h busy=%b want 0000 1", mem_if.MEM_ADDR, BUSY);
      end
      @(posedge clk); #1;
      RESET_X = 1'b0;
      #1;
      checks++;
      if ({mem_if.MEM_WE, mem_if.MEM_ADDR, mem_if.MEM_WDATA, mem_if.MEM_BE, BUSY, DONE, OVERFLOW} !== 56'd0) begin
         errors++;
         $display("FAIL midjob_reset got we=%b addr=%h busy=%b done=%b want all 0",
                  mem_if.MEM_WE, mem_if.MEM_ADDR, BUSY, DONE);
      end
      repeat (2) @(posedge clk);
      #1;
      RESET_X = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (DONE !== 1'b0 || BUSY !== 1'b0 || mem_if.MEM_WE !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles want 0", seen); end
      // Only an idle FSM answers a zero-length START with DONE next cycle.
      @(posedge clk); #1;
      START = 1'b1; NUM_ELEM = 16'd0;
      @(posedge clk); #1;
      START = 1'b0;
      @(negedge clk);
      checks++;
      if (DONE !== 1'b1) begin errors++; $display("FAIL post_reset_idle got done=%b want 1", DONE); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_pack();
      test_zero();
      test_overflow();
      test_toggle();
      test_random();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
